// File: rtl/compand_pkg.sv
// Shared constants and helpers for the linear-to-A-law compander pipeline.
package compand_pkg;

  localparam logic [7:0] ALAW_XOR = 8'h55;
  localparam int MAG_MAX  = 4095;
  localparam int SEG_BASE = 32;
  localparam int CNT_W    = 16;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alaw_seg_enc.sv
// A-law segment/mantissa encoder for a 12-bit magnitude.
module alaw_seg_enc (
  input  logic [11:0] mag_i,
  output logic [2:0]  seg_o,
  output logic [3:0]  mant_o
);

  // Leading one at bit seg+4 selects the segment; below 32 is segment 0.
  always_comb begin
    seg_o  = 3'd0;
    mant_o = mag_i[4:1];
    priority case (1'b1)
      mag_i[11]: begin
        seg_o  = 3'd7;
        mant_o = mag_i[10:7];
      end
      mag_i[10]: begin
        seg_o  = 3'd6;
        mant_o = mag_i[9:6];
      end
      mag_i[9]: begin
        seg_o  = 3'd5;
        mant_o = mag_i[8:5];
      end
      mag_i[8]: begin
        seg_o  = 3'd4;
        mant_o = mag_i[7:4];
      end
      mag_i[7]: begin
        seg_o  = 3'd3;
        mant_o = mag_i[6:3];
      end
      mag_i[6]: begin
        seg_o  = 3'd2;
        mant_o = mag_i[5:2];
      end
      mag_i[5]: begin
        seg_o  = 3'd1;
        mant_o = mag_i[4:1];
      end
      default: begin
        seg_o  = 3'd0;
        mant_o = mag_i[4:1];
      end
    endcase
  end

endmodule

// File: rtl/compand_pipe.sv
// Two-stage linear PCM to G.711 A-law encoder with
// per-channel clip counters and valid/ready flow control.
module compand_pipe
  import compand_pkg::*;
#(
  parameter  int IN_WIDTH = 13,
  parameter  int NCH      = 4,
  localparam int CH_W     = ch_w(NCH)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [IN_WIDTH-1:0]  IN_DATA,
  input  logic [CH_W-1:0]      IN_CH,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [7:0]           OUT_DATA,
  output logic [CH_W-1:0]      OUT_CH,
  input  logic                 SAT_CLR,
  output logic [CNT_W*NCH-1:0] SAT_CNT
);

  localparam int SH = IN_WIDTH - 13;

  logic s2_en;
  logic s1_en;
  logic in_fire;

  logic                in_sign;
  logic [IN_WIDTH:0]   in_ext;
  logic [IN_WIDTH:0]   in_abs;
  logic [IN_WIDTH:0]   in_shr;
  logic                in_clip;
  logic [11:0]         in_mag;

  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q, s1_sign_d;
  logic [11:0]         s1_mag_q, s1_mag_d;
  logic [CH_W-1:0]     s1_ch_q, s1_ch_d;

  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;

  logic [2:0]          seg;
  logic [3:0]          mant;
  logic [7:0]          code;

  logic [CNT_W-1:0]    cnt_q [NCH];
  logic [CNT_W-1:0]    cnt_d [NCH];

  assign s2_en     = ~out_valid_q | OUT_READY;
  assign s1_en     = ~s1_valid_q | s2_en;
  // No handshake may complete while RESET is high.
  assign IN_READY  = s1_en & ~RESET;
  assign OUT_VALID = out_valid_q & ~RESET;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;
  assign in_fire   = IN_VALID & IN_READY;

  always_comb begin
    in_sign = IN_DATA[IN_WIDTH-1];
    in_ext  = {in_sign, IN_DATA};
    in_abs  = in_sign ? -in_ext : in_ext;
    in_shr  = in_abs >> SH;
    in_clip = in_shr > (IN_WIDTH+1)'(MAG_MAX);
    in_mag  = in_clip ? 12'(MAG_MAX) : in_shr[11:0];
  end

  alaw_seg_enc u_seg (
    .mag_i  (s1_mag_q),
    .seg_o  (seg),
    .mant_o (mant)
  );

  assign code = {~s1_sign_q, seg, mant} ^ ALAW_XOR;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_ch_d    = s1_ch_q;
    if (s1_en) begin
      s1_valid_d = IN_VALID;
      if (IN_VALID) begin
        s1_sign_d = in_sign;
        s1_mag_d  = in_mag;
        s1_ch_d   = IN_CH;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = code;
        out_ch_d   = s1_ch_q;
      end
    end
  end

  // Tags at or above NCH never match k, so they leave every counter alone.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (SAT_CLR) begin
        cnt_d[k] = '0;
      end else if (in_fire && in_clip &&
                   IN_CH == CH_W'(k) &&
                   cnt_q[k] != '1) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    SAT_CNT = '0;
    for (int k = 0; k < NCH; k++) begin
      SAT_CNT[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s1_ch_q     <= s1_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule
